// File: rtl/cache_pkg.sv
// Shared widths and controller state encoding for the data cache and its memory port.
package cache_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int OFFSET_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        FILL   = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared by synchronous reset.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/cache_miss_handler.sv
// Load-miss refill and store write-through controller for a direct-mapped data cache.
// Stalls the MEM stage while a memory transaction or cache overwrite is outstanding.
module cache_miss_handler #(
    parameter int DATA_WIDTH   = cache_pkg::DATA_WIDTH,
    parameter int OFFSET_WIDTH = cache_pkg::OFFSET_WIDTH,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic                  lookup_we,
    input  logic [DATA_WIDTH-1:0] lookup_addr,
    input  logic [DATA_WIDTH-1:0] lookup_wdata,
    input  logic                  cache_hit,
    output logic                  stall,
    output logic                  fill_en,
    output logic [DATA_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    import cache_pkg::*;

    localparam logic [DATA_WIDTH-1:0] ADDR_MASK =
        {{(DATA_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [DATA_WIDTH-1:0] r_wdata_q;
    logic                  r_hit_q;
    logic                  r_we_q;

    logic                  w_cap_load;
    logic                  w_cap_store;
    logic                  w_cap_rdata;
    logic                  w_miss_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr_q  <= '0;
            r_data_q  <= '0;
            r_wdata_q <= '0;
            r_hit_q   <= 1'b0;
            r_we_q    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_cap_load || w_cap_store) begin
                r_addr_q <= lookup_addr & ADDR_MASK;
                r_we_q   <= w_cap_store;
                r_hit_q  <= w_cap_store & cache_hit;
            end
            if (w_cap_store) begin
                r_wdata_q <= lookup_wdata;
            end
            if (w_cap_rdata) begin
                r_data_q <= mem_rdata;
            end
        end
    end

    // Outputs are zero outside the state that owns them, so idle buses read as 0.
    always_comb begin
        w_state_next = r_state;
        w_cap_load   = 1'b0;
        w_cap_store  = 1'b0;
        w_cap_rdata  = 1'b0;
        w_miss_inc   = 1'b0;
        fill_en      = 1'b0;
        fill_addr    = '0;
        fill_data    = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (r_state)
            IDLE: begin
                if (lookup_valid) begin
                    if (lookup_we) begin
                        w_cap_store  = 1'b1;
                        w_state_next = WR_REQ;
                    end else if (!cache_hit) begin
                        w_cap_load   = 1'b1;
                        w_miss_inc   = 1'b1;
                        w_state_next = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = r_addr_q;
                if (mem_ack) begin
                    w_cap_rdata  = 1'b1;
                    w_state_next = FILL;
                end
            end
            WR_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr_q;
                mem_wdata = r_wdata_q;
                // No write-allocate: only a store that hit updates the cache copy.
                if (mem_ack) begin
                    w_state_next = r_hit_q ? FILL : IDLE;
                end
            end
            FILL: begin
                fill_en      = 1'b1;
                fill_addr    = r_addr_q;
                fill_data    = r_we_q ? r_wdata_q : r_data_q;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign stall = (r_state != IDLE) || (lookup_valid && (lookup_we || !cache_hit));

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_miss_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_miss_inc),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler; inputs change 1ns after posedge, outputs sampled at negedge.
module tb_cache_miss_handler;

    localparam int DW = 32;
    localparam int CW = 8;  // narrow counter so saturation is reached in a few hundred misses

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_valid;
    logic          lookup_we;
    logic [DW-1:0] lookup_addr;
    logic [DW-1:0] lookup_wdata;
    logic          cache_hit;
    logic          stall;
    logic          fill_en;
    logic [DW-1:0] fill_addr;
    logic [DW-1:0] fill_data;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] miss_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_miss_handler #(
        .DATA_WIDTH   (DW),
        .OFFSET_WIDTH (2),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_we    (lookup_we),
        .lookup_addr  (lookup_addr),
        .lookup_wdata (lookup_wdata),
        .cache_hit    (cache_hit),
        .stall        (stall),
        .fill_en      (fill_en),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .miss_count   (miss_count)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        lookup_valid = 1'b0;
        lookup_we    = 1'b0;
        lookup_addr  = '0;
        lookup_wdata = '0;
        cache_hit    = 1'b0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        sample();
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", stall); end
        n_vec++; if (fill_en !== 1'b0) begin n_err++; $display("FAIL rst_fill_en got %b want 0", fill_en); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        n_vec++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
        n_vec++; if (fill_addr !== 32'h0) begin n_err++; $display("FAIL rst_fill_addr got %h want 0", fill_addr); end
        n_vec++; if (fill_data !== 32'h0) begin n_err++; $display("FAIL rst_fill_data got %h want 0", fill_data); end
        n_vec++; if (miss_count !== 8'h00) begin n_err++; $display("FAIL rst_miss_count got %h want 0", miss_count); end
        next_cycle();
        $display("reset: outputs checked");
    endtask

    task automatic test_load_hit();
        lookup_valid = 1'b1;
        lookup_we    = 1'b0;
        lookup_addr  = 32'h0000_0010;
        cache_hit    = 1'b1;
        sample();
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ldhit_stall got %b want 0", stall); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ldhit_mem_req got %b want 0", mem_req); end
        next_cycle();
        idle_inputs();
        sample();
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ldhit_mem_req_c1 got %b want 0", mem_req); end
        n_vec++; if (miss_count !== 8'h00) begin n_err++; $display("FAIL ldhit_miss_count got %h want 0", miss_count); end
        next_cycle();
        $display("load hit addr=00000010");
    endtask

    task automatic test_load_miss();
        // cycle 0: miss presented
        lookup_valid = 1'b1;
        lookup_we    = 1'b0;
        lookup_addr  = 32'h0000_0046;
        cache_hit    = 1'b0;
        sample();
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL ldmiss_stall_c0 got %b want 1", stall); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ldmiss_mem_req_c0 got %b want 0", mem_req); end
        // cycles 1..4: request outstanding, ack in cycle 4 (L=3)
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            mem_ack   = (c == 4);
            mem_rdata = (c == 4) ? 32'hDEAD_BEEF : 32'h5555_5555;
            sample();
            n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL ldmiss_mem_req c%0d got %b want 1", c, mem_req); end
            n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL ldmiss_mem_we c%0d got %b want 0", c, mem_we); end
            n_vec++; if (mem_addr !== 32'h0000_0044) begin n_err++; $display("FAIL ldmiss_mem_addr c%0d got %h want 00000044", c, mem_addr); end
            n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL ldmiss_stall c%0d got %b want 1", c, stall); end
            n_vec++; if (fill_en !== 1'b0) begin n_err++; $display("FAIL ldmiss_fill_en c%0d got %b want 0", c, fill_en); end
        end
        // cycle 5: fill
        next_cycle();
        mem_ack   = 1'b0;
        mem_rdata = 32'hAAAA_AAAA;
        sample();
        n_vec++; if (fill_en !== 1'b1) begin n_err++; $display("FAIL ldmiss_fill_en_c5 got %b want 1", fill_en); end
        n_vec++; if (fill_addr !== 32'h0000_0044) begin n_err++; $display("FAIL ldmiss_fill_addr got %h want 00000044", fill_addr); end
        n_vec++; if (fill_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ldmiss_fill_data got %h want deadbeef", fill_data); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ldmiss_mem_req_c5 got %b want 0", mem_req); end
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL ldmiss_stall_c5 got %b want 1", stall); end
        // cycle 6: replayed load hits
        next_cycle();
        cache_hit = 1'b1;
        sample();
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ldmiss_stall_c6 got %b want 0", stall); end
        n_vec++; if (fill_en !== 1'b0) begin n_err++; $display("FAIL ldmiss_fill_en_c6 got %b want 0", fill_en); end
        n_vec++; if (miss_count !== 8'h01) begin n_err++; $display("FAIL ldmiss_miss_count got %h want 01", miss_count); end
        next_cycle();
        idle_inputs();
        $display("load miss addr=00000046 L=3 data=deadbeef");
    endtask

    task automatic test_store_hit();
        lookup_valid = 1'b1;
        lookup_we    = 1'b1;
        lookup_addr  = 32'h0000_0020;
        lookup_wdata = 32'h1234_5678;
        cache_hit    = 1'b1;
        sample();
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL sthit_stall_c0 got %b want 1", stall); end
        // cycle 1: lookup bus changes while busy and must be ignored
        next_cycle();
        lookup_addr  = 32'h0000_0099;
        lookup_wdata = 32'hFFFF_FFFF;
        mem_ack      = 1'b1;
        sample();
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL sthit_mem_req got %b want 1", mem_req); end
        n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL sthit_mem_we got %b want 1", mem_we); end
        n_vec++; if (mem_addr !== 32'h0000_0020) begin n_err++; $display("FAIL sthit_mem_addr got %h want 00000020", mem_addr); end
        n_vec++; if (mem_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL sthit_mem_wdata got %h want 12345678", mem_wdata); end
        // cycle 2: cache copy updated
        next_cycle();
        idle_inputs();
        sample();
        n_vec++; if (fill_en !== 1'b1) begin n_err++; $display("FAIL sthit_fill_en got %b want 1", fill_en); end
        n_vec++; if (fill_addr !== 32'h0000_0020) begin n_err++; $display("FAIL sthit_fill_addr got %h want 00000020", fill_addr); end
        n_vec++; if (fill_data !== 32'h1234_5678) begin n_err++; $display("FAIL sthit_fill_data got %h want 12345678", fill_data); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL sthit_mem_req_c2 got %b want 0", mem_req); end
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL sthit_stall_c2 got %b want 1", stall); end
        next_cycle();
        sample();
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL sthit_stall_c3 got %b want 0", stall); end
        n_vec++; if (fill_en !== 1'b0) begin n_err++; $display("FAIL sthit_fill_en_c3 got %b want 0", fill_en); end
        n_vec++; if (miss_count !== 8'h01) begin n_err++; $display("FAIL sthit_miss_count got %h want 01", miss_count); end
        next_cycle();
        $display("store hit addr=00000020 data=12345678 L=0");
    endtask

    task automatic test_store_miss();
        lookup_valid = 1'b1;
        lookup_we    = 1'b1;
        lookup_addr  = 32'h0000_0033;
        lookup_wdata = 32'hCAFE_F00D;
        cache_hit    = 1'b0;
        sample();
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL stmiss_stall_c0 got %b want 1", stall); end
        next_cycle();
        idle_inputs();
        mem_ack = 1'b1;
        sample();
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL stmiss_mem_req got %b want 1", mem_req); end
        n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL stmiss_mem_we got %b want 1", mem_we); end
        n_vec++; if (mem_addr !== 32'h0000_0030) begin n_err++; $display("FAIL stmiss_mem_addr got %h want 00000030", mem_addr); end
        n_vec++; if (mem_wdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL stmiss_mem_wdata got %h want cafef00d", mem_wdata); end
        next_cycle();
        mem_ack = 1'b0;
        sample();
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL stmiss_stall_c2 got %b want 0", stall); end
        n_vec++; if (fill_en !== 1'b0) begin n_err++; $display("FAIL stmiss_fill_en got %b want 0", fill_en); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL stmiss_mem_req_c2 got %b want 0", mem_req); end
        n_vec++; if (miss_count !== 8'h01) begin n_err++; $display("FAIL stmiss_miss_count got %h want 01", miss_count); end
        next_cycle();
        $display("store miss addr=00000033 data=cafef00d L=0");
    endtask

    task automatic test_spurious_ack();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_0000 + c;
            sample();
            n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL spur_mem_req c%0d got %b want 0", c, mem_req); end
            n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL spur_stall c%0d got %b want 0", c, stall); end
            next_cycle();
        end
        mem_ack = 1'b0;
        sample();
        n_vec++; if (fill_en !== 1'b0) begin n_err++; $display("FAIL spur_fill_en got %b want 0", fill_en); end
        n_vec++; if (miss_count !== 8'h01) begin n_err++; $display("FAIL spur_miss_count got %h want 01", miss_count); end
        next_cycle();
        $display("spurious ack in idle");
    endtask

    task automatic do_miss(input logic [DW-1:0] addr);
        lookup_valid = 1'b1;
        lookup_we    = 1'b0;
        lookup_addr  = addr;
        cache_hit    = 1'b0;
        next_cycle();
        lookup_valid = 1'b0;
        mem_ack      = 1'b1;
        next_cycle();
        mem_ack      = 1'b0;
        next_cycle();
    endtask

    task automatic test_saturation();
        // count is 1 here; bring it to all-ones minus one
        for (int i = 0; i < 253; i++) begin
            do_miss(32'h0000_1000 + 4 * i);
        end
        sample();
        n_vec++; if (miss_count !== 8'hFE) begin n_err++; $display("FAIL sat_preload got %h want fe", miss_count); end
        next_cycle();
        do_miss(32'h0000_2000);
        sample();
        n_vec++; if (miss_count !== 8'hFF) begin n_err++; $display("FAIL sat_first got %h want ff", miss_count); end
        next_cycle();
        do_miss(32'h0000_2004);
        sample();
        n_vec++; if (miss_count !== 8'hFF) begin n_err++; $display("FAIL sat_hold got %h want ff", miss_count); end
        next_cycle();
        $display("saturation: 255 misses then one more");
    endtask

    task automatic test_reset_mid();
        lookup_valid = 1'b1;
        lookup_we    = 1'b0;
        lookup_addr  = 32'h0000_0050;
        cache_hit    = 1'b0;
        next_cycle();
        lookup_valid = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;  // during wait cycle 2 (cycle 3)
        sample();
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rmid_mem_req_pre got %b want 1", mem_req); end
        next_cycle();
        rst     = 1'b0;
        mem_ack = 1'b1;  // late ack must be ignored after reset
        mem_rdata = 32'h0BAD_F111;
        sample();
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rmid_mem_req got %b want 0", mem_req); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rmid_stall got %b want 0", stall); end
        n_vec++; if (miss_count !== 8'h00) begin n_err++; $display("FAIL rmid_miss_count got %h want 00", miss_count); end
        next_cycle();
        mem_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sample();
            n_vec++; if (fill_en !== 1'b0) begin n_err++; $display("FAIL rmid_fill_en c%0d got %b want 0", c, fill_en); end
            n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rmid_mem_req_after c%0d got %b want 0", c, mem_req); end
            next_cycle();
        end
        $display("reset during read wait");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_hit();
        test_load_miss();
        test_store_hit();
        test_store_miss();
        test_spurious_ack();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Miss/refill and write-through controller sitting directly downstream of the direct-mapped data cache in the MEM stage. It watches each lookup and the cache's hit flag. On a load miss it fetches the word from main memory and drives the cache's overwrite port to install it. Stores are written through to memory, and the cache copy is updated on a hit. The pipeline is stalled until each access completes.

## Interface
- DATA_WIDTH, 32, data and address width
- OFFSET_WIDTH, 2, byte-offset bits forced to zero on memory addresses
- CNT_WIDTH, 16, width of the saturating miss counter

- clk  input  1  clock
- rst  input  1  reset; one clock, synchronous, active-high
- lookup_valid  input  1  MEM stage presents a load or store this cycle
- lookup_we  input  1  1 = store, 0 = load
- lookup_addr  input  DATA_WIDTH  byte address of the access
- lookup_wdata  input  DATA_WIDTH  store data
- cache_hit  input  1  hit flag from the cache for lookup_addr, same cycle
- stall  output  1  hold the pipeline (combinational)
- fill_en  output  1  overwrite strobe to the cache
- fill_addr  output  DATA_WIDTH  address written into the cache
- fill_data  output  DATA_WIDTH  data written into the cache
- mem_req  output  1  memory request valid
- mem_we  output  1  memory write
- mem_addr  output  DATA_WIDTH  word-aligned memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_ack  input  1  memory completes the current request (read data valid this cycle)
- mem_rdata  input  DATA_WIDTH  memory read data
- miss_count  output  CNT_WIDTH  saturating count of load misses

## Operation
- States: IDLE, RD_REQ, WR_REQ, FILL.
- IDLE, lookup_valid, !lookup_we, cache_hit:
  - Stays in IDLE; stall=0.
- IDLE, lookup_valid, !lookup_we, !cache_hit:
  - Latches the address into addr_q with the low OFFSET_WIDTH bits cleared.
  - Increments miss_count (saturates at all-ones, no wrap).
  - Goes to RD_REQ.
- IDLE, lookup_valid, lookup_we:
  - Latches addr_q, wdata_q and hit_q=cache_hit.
  - Goes to WR_REQ. Stores never count as misses; there is no write-allocate.
- RD_REQ:
  - Drives mem_req=1, mem_we=0, mem_addr=addr_q.
  - On mem_ack, latches mem_rdata into data_q and goes to FILL.
- WR_REQ:
  - Drives mem_req=1, mem_we=1, mem_addr=addr_q, mem_wdata=wdata_q.
  - On mem_ack, goes to FILL if hit_q, else to IDLE.
- FILL:
  - Drives fill_en=1, fill_addr=addr_q, fill_data=data_q (read) or wdata_q (store).
  - Always returns to IDLE.
- stall = (state != IDLE) || (lookup_valid && (lookup_we || !cache_hit)).
- The pipeline re-presents the same access after stall drops. A re-presented load hits; a re-presented store is not repeated because the stage has already advanced.
- mem_ack outside RD_REQ/WR_REQ is ignored.
- mem_addr, mem_wdata and mem_we hold stable while mem_req=1.
- lookup_* are ignored outside IDLE.

## Timing
- Reset values: state=IDLE, stall=0 when lookup_valid=0, fill_en=0, mem_req=0, mem_we=0, fill_addr/fill_data/mem_addr/mem_wdata=0, miss_count=0.
- Load miss detected in cycle 0:
  - mem_req rises in cycle 1.
  - With mem_ack in cycle 1+L (L≥0 wait cycles), fill_en is high in cycle 2+L.
  - stall is high for cycles 0 to 2+L; the replayed lookup hits in cycle 3+L.
- Store hit: same timing as a load miss. Store miss: no FILL cycle, so stall is high for cycles 0 to 1+L.
- Load hit: zero added latency.
- fill_en is exactly one cycle per fill. mem_req drops in the cycle after mem_ack.
- Reset mid-operation:
  - Returns to IDLE on the next edge and drops mem_req.
  - Any in-flight fill is discarded with no fill_en.
  - Clears miss_count.

## Structure
- Shared package cache_pkg holds DATA_WIDTH, OFFSET_WIDTH and the state enum (IDLE, RD_REQ, WR_REQ, FILL), so the cache and the memory interface agree on widths.
- There is one sub-module, sat_counter (parameter CNT_WIDTH, ports clk, rst, inc, count), used for miss_count.
- Everything else is a single FSM with a datapath register set: addr_q, data_q, wdata_q, hit_q.

## Test plan
- Load hit: lookup_valid=1, we=0, addr=0x0000_0010, cache_hit=1 -> stall=0, no mem_req, miss_count stays 0.
- Load miss with L=3: addr=0x0000_0046, cache_hit=0, mem_rdata=0xDEAD_BEEF ->
  - mem_req with mem_addr=0x0000_0044 for cycles 1 to 4.
  - fill_en in cycle 5 with fill_addr=0x0000_0044, fill_data=0xDEAD_BEEF.
  - stall low in cycle 6; miss_count=1.
- Store hit with L=0: addr=0x0000_0020, wdata=0x1234_5678, cache_hit=1 ->
  - mem_we=1 in cycle 1.
  - fill_en in cycle 2 with fill_data=0x1234_5678.
  - miss_count unchanged.
- Store miss with L=0: cache_hit=0 -> mem write in cycle 1, no fill_en, stall low in cycle 2.
- Saturation/robustness:
  - Preload miss_count to 0xFFFE via 65534 misses; two further misses -> miss_count=0xFFFF.
  - A spurious mem_ack in IDLE has no effect.
- Reset mid-RD_REQ: assert rst during wait cycle 2 -> the next cycle has mem_req=0, state IDLE, miss_count=0, and no fill_en ever occurs.
